// File: rtl/alu_divseq_pkg.sv
// rtl/alu_divseq_pkg.sv - shared ALU opcodes and divider state encoding
//
// Purpose: constants shared by the execute-stage ALU and the sequential
// divider that borrows it.
// Contents:
//   ALU_* : 8-bit ALU opcode values
//   divseq_state_t : alu_divseq FSM state encoding

package alu_divseq_pkg;

  localparam logic [7:0] ALU_ADD   = 8'd0;
  localparam logic [7:0] ALU_SUB   = 8'd2;
  localparam logic [7:0] ALU_OR    = 8'd4;
  localparam logic [7:0] ALU_AND   = 8'd5;
  localparam logic [7:0] ALU_NOT   = 8'd6;
  localparam logic [7:0] ALU_XOR   = 8'd7;
  localparam logic [7:0] ALU_CMP   = 8'd8;
  localparam logic [7:0] ALU_PASS  = 8'd9;
  localparam logic [7:0] ALU_SHL   = 8'd12;
  localparam logic [7:0] ALU_SHR   = 8'd13;
  localparam logic [7:0] ALU_MULLO = 8'd17;
  localparam logic [7:0] ALU_MULHI = 8'd18;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ABSA = 3'd1,
    S_ABSB = 3'd2,
    S_ITER = 3'd3,
    S_NEGQ = 3'd4,
    S_NEGR = 3'd5,
    S_DONE = 3'd6
  } divseq_state_t;

endpackage

// File: rtl/alu_divseq.sv
// rtl/alu_divseq.sv - multi-cycle 32-bit restoring divider using the shared ALU
//
// Purpose: signed/unsigned 32-bit division built only from ALU subtractions.
// While alu_own is high the CPU top level routes alu_a/alu_b/alu_op onto the
// shared ALU and returns its combinational result on alu_c.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, is_signed    : request a division (accepted only in IDLE)
//   dividend, divisor   : operands, sampled with start
//   busy, done          : busy outside IDLE; done pulses one cycle at the end
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : set when the accepted divisor was zero
//   alu_own             : this block drives the ALU this cycle
//   alu_a, alu_b, alu_op: ALU request (all zero when not owning)
//   alu_c               : ALU result, same cycle

module alu_divseq
  import alu_divseq_pkg::*;
#(
  parameter logic [7:0] OP_SUB = ALU_SUB,
  parameter int         NSTEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [7:0]  alu_op,
  input  logic [31:0] alu_c
);

  localparam logic [4:0] LAST_STEP = 5'(NSTEPS - 1);

  divseq_state_t state, state_n;

  logic [31:0] dvd, dvd_n;   // dividend shift register (magnitude once signed)
  logic [31:0] dvs, dvs_n;   // divisor (magnitude once signed)
  logic [31:0] q, q_n;       // quotient shift register
  logic [31:0] rem, rem_n;   // partial remainder
  logic [4:0]  step, step_n;
  logic        sgn, sgn_n;
  logic        qneg, qneg_n;
  logic        rneg, rneg_n;
  logic        dz, dz_n;

  logic [31:0] x;
  logic        borrow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      dvd   <= '0;
      dvs   <= '0;
      q     <= '0;
      rem   <= '0;
      step  <= '0;
      sgn   <= 1'b0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      dvd   <= dvd_n;
      dvs   <= dvs_n;
      q     <= q_n;
      rem   <= rem_n;
      step  <= step_n;
      sgn   <= sgn_n;
      qneg  <= qneg_n;
      rneg  <= rneg_n;
      dz    <= dz_n;
    end
  end

  always_comb begin
    state_n = state;
    dvd_n   = dvd;
    dvs_n   = dvs;
    q_n     = q;
    rem_n   = rem;
    step_n  = step;
    sgn_n   = sgn;
    qneg_n  = qneg;
    rneg_n  = rneg;
    dz_n    = dz;
    alu_own = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    done    = 1'b0;
    busy    = (state != S_IDLE);
    x       = '0;
    borrow  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          sgn_n  = is_signed;
          dvd_n  = dividend;
          dvs_n  = divisor;
          step_n = '0;
          if (divisor == 32'd0) begin
            q_n     = 32'hFFFF_FFFF;
            rem_n   = dividend;
            dz_n    = 1'b1;
            state_n = S_DONE;
          end else begin
            q_n     = '0;
            rem_n   = '0;
            dz_n    = 1'b0;
            state_n = is_signed ? S_ABSA : S_ITER;
          end
        end
      end

      S_ABSA: begin
        alu_own = 1'b1;
        alu_op  = OP_SUB;
        alu_b   = dvd;
        if (dvd[31]) dvd_n = alu_c;
        // Both operands are still raw here, so the result signs come from them.
        qneg_n  = dvd[31] ^ dvs[31];
        rneg_n  = dvd[31];
        state_n = S_ABSB;
      end

      S_ABSB: begin
        alu_own = 1'b1;
        alu_op  = OP_SUB;
        alu_b   = dvs;
        if (dvs[31]) dvs_n = alu_c;
        state_n = S_ITER;
      end

      S_ITER: begin
        alu_own = 1'b1;
        alu_op  = OP_SUB;
        x       = {rem[30:0], dvd[31]};
        alu_a   = x;
        alu_b   = dvs;
        // The shifted remainder is 33 bits wide with rem[31] on top; when that
        // bit is set the value exceeds any divisor. Otherwise x < dvs unsigned
        // is recovered from the operand signs and the 32-bit difference sign.
        borrow  = ~rem[31] & ((~x[31] & dvs[31]) | (~(x[31] ^ dvs[31]) & alu_c[31]));
        if (borrow) begin
          rem_n = x;
          q_n   = {q[30:0], 1'b0};
        end else begin
          rem_n = alu_c;
          q_n   = {q[30:0], 1'b1};
        end
        dvd_n  = {dvd[30:0], 1'b0};
        step_n = step + 5'd1;
        if (step == LAST_STEP) state_n = sgn ? S_NEGQ : S_DONE;
      end

      S_NEGQ: begin
        alu_own = 1'b1;
        alu_op  = OP_SUB;
        alu_b   = q;
        if (qneg) q_n = alu_c;
        state_n = S_NEGR;
      end

      S_NEGR: begin
        alu_own = 1'b1;
        alu_op  = OP_SUB;
        alu_b   = rem;
        if (rneg) rem_n = alu_c;
        state_n = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dz;

endmodule

// File: tb/tb_alu_divseq.sv
// tb/tb_alu_divseq.sv - scoreboard bench for alu_divseq with a behavioural ALU

module tb_alu_divseq;
  import alu_divseq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [7:0]  alu_op;
  logic [31:0] alu_c;

  // CPU side is idle in this bench; the ownership mux selects the divider.
  logic [31:0] mux_a, mux_b;
  logic [7:0]  mux_op;

  always #5 clk = ~clk;

  alu_divseq dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c)
  );

  always_comb begin
    mux_a  = alu_own ? alu_a  : 32'd0;
    mux_b  = alu_own ? alu_b  : 32'd0;
    mux_op = alu_own ? alu_op : 8'd0;
    case (mux_op)
      ALU_ADD: alu_c = mux_a + mux_b;
      ALU_SUB: alu_c = mux_a - mux_b;
      ALU_OR:  alu_c = mux_a | mux_b;
      ALU_AND: alu_c = mux_a & mux_b;
      ALU_XOR: alu_c = mux_a ^ mux_b;
      default: alu_c = 32'd0;
    endcase
  end

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    logic        own;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat_cnt = 0;
  logic own_seen = 1'b0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: tracks latency and ALU usage, compares results whenever done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (start && !busy) begin
        lat_cnt  = 0;
        own_seen = 1'b0;
      end else begin
        lat_cnt++;
      end
      if (alu_own) own_seen = 1'b1;

      if (alu_own) check32("alu_op_owned", {24'd0, alu_op}, {24'd0, ALU_SUB});
      else         check32("alu_bus_idle", alu_a | alu_b | {24'd0, alu_op}, 32'd0);

      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check32({e.name, "_quotient"},  quotient, e.q);
          check32({e.name, "_remainder"}, remainder, e.r);
          check32({e.name, "_dz"},        {31'd0, div_by_zero}, {31'd0, e.dz});
          check32({e.name, "_latency"},   lat_cnt, e.lat);
          check32({e.name, "_alu_own"},   {31'd0, own_seen}, {31'd0, e.own});
        end
      end
    end
  end

  task automatic issue(input string nm, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input int lat, input logic own);
    exp_t e;
    e.name = nm; e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.own = own;
    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", nm, n);
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_busy",      {31'd0, busy}, 32'd0);
    check32("reset_done",      {31'd0, done}, 32'd0);
    check32("reset_quotient",  quotient, 32'd0);
    check32("reset_remainder", remainder, 32'd0);
    check32("reset_dz",        {31'd0, div_by_zero}, 32'd0);
    check32("reset_alu_own",   {31'd0, alu_own}, 32'd0);
    reset = 1'b0;

    issue("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    wait_drain("u100_7");
    issue("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 37, 1'b1);
    wait_drain("s_m7_2");
    issue("u_borrow33", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 1'b1);
    wait_drain("u_borrow33");
    issue("dz_1234", 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 1'b0);
    wait_drain("dz_1234");
    issue("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 37, 1'b1);
    wait_drain("s_ovf");
    issue("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 37, 1'b1);
    wait_drain("s_m100_m7");

    // Abort: a long division whose quotient is nonzero mid-flight, a stray
    // start while busy, then reset.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd50; divisor = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("abort_still_busy", {31'd0, busy}, 32'd1);
    check32("abort_stray_start_ignored", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check32("abort_busy",      {31'd0, busy}, 32'd0);
    check32("abort_quotient",  quotient, 32'd0);
    check32("abort_remainder", remainder, 32'd0);
    check32("abort_alu_own",   {31'd0, alu_own}, 32'd0);

    issue("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 1'b1);
    wait_drain("u9_3");

    // Results persist in IDLE after completion.
    repeat (3) @(posedge clk);
    #1;
    check32("hold_quotient",  quotient, 32'd3);
    check32("hold_remainder", remainder, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_divseq.md
Name: alu_divseq

Overview:
Multi-cycle 32-bit integer divider that borrows the shared combinational ALU.
- Performs signed or unsigned restoring division using only ALU opcode 2 (SUB, c = a - b).
- Sits beside the CPU execute stage. While alu_own is high, the CPU top level multiplexes alu_a/alu_b/alu_op from this block onto the ALU inputs and returns the ALU result on alu_c.
- Quotient, remainder and a divide-by-zero flag are registered until the next start.

Parameters:
- OP_SUB, 8'd2, ALU opcode driven during every ALU-using state.
- NSTEPS, 32, number of restoring iterations; equals the operand width and is not to be changed.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a division; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- dividend  input  32  sampled with start
- divisor  input  32  sampled with start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; results are valid from this cycle on
- quotient  output  32  registered quotient
- remainder  output  32  registered remainder
- div_by_zero  output  1  registered; set when divisor == 0
- alu_own  output  1  block owns the ALU this cycle
- alu_a  output  32  ALU operand a; 0 when not owning
- alu_b  output  32  ALU operand b; 0 when not owning
- alu_op  output  8  OP_SUB when owning, else 0
- alu_c  input  32  ALU result (combinational, same cycle)

Behaviour:
- Reset:
  - state = IDLE.
  - busy, done, alu_own, div_by_zero = 0.
  - quotient, remainder, alu_a, alu_b, alu_op = 0.
  - Reset mid-operation aborts immediately; there is no partial result.
- States: IDLE, ABSA, ABSB, ITER, NEGQ, NEGR, DONE.
- IDLE:
  - start=1 latches the operands and is_signed.
  - If divisor == 0: next state is DONE with quotient = 32'hFFFF_FFFF, remainder = dividend (raw), div_by_zero = 1.
  - Otherwise div_by_zero = 0; next state is ABSA if signed, ITER if unsigned.
- ABSA:
  - alu_a = 0, alu_b = dvd; latch dvd = alu_c if dvd[31], else keep dvd.
  - Record qneg = dividend[31] ^ divisor[31] and rneg = dividend[31].
- ABSB: same as ABSA, applied to dvs.
- ITER (step counter 0..31):
  - x = {rem[30:0], dvd[31]}; alu_a = x; alu_b = dvs.
  - borrow = (rem[31] == 0) & ((~x[31] & dvs[31]) | (~(x[31] ^ dvs[31]) & alu_c[31])).
  - rem[31] is the 33rd bit of the shifted remainder.
  - If borrow: rem = x, quotient bit = 0. Otherwise: rem = alu_c, quotient bit = 1.
  - dvd shifts left one bit; the quotient bit enters at the LSB of the quotient shift register.
  - After step 31 the next state is NEGQ if signed, DONE if unsigned.
- NEGQ: alu_a = 0, alu_b = q; q = alu_c if qneg, else unchanged.
- NEGR: the same on rem using rneg.
- DONE:
  - done = 1 for exactly one cycle; quotient/remainder/div_by_zero are already valid.
  - Next state is IDLE. A start in DONE is ignored.
- start while busy is ignored.
- Outputs hold their values until the next accepted start.
- Latency from the start cycle to the done cycle:
  - unsigned: 33 cycles
  - signed: 37 cycles
  - divide-by-zero: 1 cycle
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: abs(dividend) = 0x8000_0000 treated as unsigned, giving quotient = 0x8000_0000, remainder = 0. No special case is needed.
- alu_own = 1 exactly in ABSA, ABSB, ITER, NEGQ and NEGR.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ADD = 0, SUB = 2, OR = 4, AND = 5, NOT = 6, XOR = 7, CMP = 8, PASS = 9, SHL = 12, SHR = 13, MULLO = 17, MULHI = 18).
  - The alu_divseq state encoding.
- Single flat module; no sub-module.
- The block does not instantiate the ALU. The test bench instantiates alu and wires it with the ownership mux.

Test Plan:
- Unsigned 100 / 7: start with is_signed = 0 -> done 33 cycles later; quotient = 14, remainder = 2, div_by_zero = 0; alu_op = 2 throughout ITER.
- Signed -7 / 2 (0xFFFF_FFF9 / 2) -> done at 37 cycles; quotient = 0xFFFF_FFFD, remainder = 0xFFFF_FFFF.
- Unsigned 0xFFFF_FFFF / 0x8000_0001 (exercises the 33-bit borrow path) -> quotient = 1, remainder = 0x7FFF_FFFE.
- Divide by zero, 1234 / 0, signed -> done 1 cycle after start; quotient = 0xFFFF_FFFF, remainder = 1234, div_by_zero = 1; alu_own never set.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> quotient = 0x8000_0000, remainder = 0.
- Start a division, pulse start again at cycle 5 (must be ignored), assert reset at cycle 10 -> next cycle busy = 0, quotient = 0, alu_own = 0. A new 9 / 3 then yields quotient = 3, remainder = 0 after 33 cycles.
